// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer and hazard controller for the 8-bit
// ADD/SUB/LOAD processor datapath.
//
// It owns the PC and the ID/EX/WB stage registers. It detects RAW hazards,
// drives the forwarding selects, inserts load-use stalls, and runs a
// run/drain/halt state machine that reacts to the HALT opcode.
//
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-high reset
//   start              begin execution at pc 0 (honoured in IDLE/HALTED only)
//   instr_in           instruction memory data at pc (combinational read)
//   pc                 fetch address
//   id/ex/wb_valid     stage holds a real instruction
//   id/ex/wb_instr     stage instruction
//   fwd_a, fwd_b       operand source: 00 regfile, 01 EX result, 10 WB result
//   stall              load-use stall this cycle
//   busy, halted       state is RUN/DRAIN, state is HALTED
//   retire_cnt         instructions retired from WB (wrapping)
module pipe_ctrl #(
  parameter int PC_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       instr_in,
  output logic [PC_W-1:0]  pc,
  output logic             id_valid,
  output logic [7:0]       id_instr,
  output logic             ex_valid,
  output logic [7:0]       ex_instr,
  output logic             wb_valid,
  output logic [7:0]       wb_instr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t           state_r, state_n;
  logic [PC_W-1:0]  pc_r, pc_n;
  logic             id_valid_r, id_valid_n, ex_valid_r, ex_valid_n, wb_valid_r, wb_valid_n;
  logic [7:0]       id_instr_r, id_instr_n, ex_instr_r, ex_instr_n, wb_instr_r, wb_instr_n;
  logic [CNT_W-1:0] retire_r, retire_n;

  logic             reads_a_s, reads_b_s, ex_alu_s, stall_s;
  logic [1:0]       fwd_a_s, fwd_b_s;

  // Forwarding select for one ID operand; EX wins over WB. Only ADD/SUB
  // results exist at the end of EX, a LOAD result is available from WB only.
  function automatic logic [1:0] fwd_sel(input logic       reads,
                                         input logic [2:0] src,
                                         input logic       ex_alu,
                                         input logic [2:0] ex_dest,
                                         input logic       wb_v,
                                         input logic [2:0] wb_dest);
    logic [1:0] sel;
    sel = 2'b00;
    if (!reads) begin
      sel = 2'b00;
    end else if (ex_alu && (ex_dest == src)) begin
      sel = 2'b01;
    end else if (wb_v && (wb_dest == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Decode which operand fields the ID instruction actually reads.
  always_comb begin
    reads_a_s = 1'b0;
    reads_b_s = 1'b0;
    if (id_valid_r) begin
      case (id_instr_r[7:6])
        OP_ADD, OP_SUB: begin
          reads_a_s = 1'b1;
          reads_b_s = 1'b1;
        end
        OP_LOAD: begin
          reads_a_s = 1'b0;
          reads_b_s = 1'b1;
        end
        default: begin
          reads_a_s = 1'b0;
          reads_b_s = 1'b0;
        end
      endcase
    end else begin
      reads_a_s = 1'b0;
      reads_b_s = 1'b0;
    end
  end

  // Hazard detection: forwarding selects and load-use stall.
  always_comb begin
    ex_alu_s = ex_valid_r && ((ex_instr_r[7:6] == OP_ADD) || (ex_instr_r[7:6] == OP_SUB));
    fwd_a_s  = fwd_sel(reads_a_s, id_instr_r[5:3], ex_alu_s, ex_instr_r[5:3],
                       wb_valid_r, wb_instr_r[5:3]);
    fwd_b_s  = fwd_sel(reads_b_s, id_instr_r[2:0], ex_alu_s, ex_instr_r[5:3],
                       wb_valid_r, wb_instr_r[5:3]);
    stall_s  = ex_valid_r && (ex_instr_r[7:6] == OP_LOAD) &&
               ((reads_a_s && (ex_instr_r[5:3] == id_instr_r[5:3])) ||
                (reads_b_s && (ex_instr_r[5:3] == id_instr_r[2:0])));
  end

  // Next-state and next-pipeline computation for the sequencer FSM.
  always_comb begin
    state_n    = state_r;
    pc_n       = pc_r;
    id_valid_n = id_valid_r;
    id_instr_n = id_instr_r;
    ex_valid_n = ex_valid_r;
    ex_instr_n = ex_instr_r;
    wb_valid_n = wb_valid_r;
    wb_instr_n = wb_instr_r;
    if (wb_valid_r) begin
      retire_n = retire_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_n = retire_r;
    end

    case (state_r)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_n    = S_RUN;
          pc_n       = {PC_W{1'b0}};
          id_valid_n = 1'b0;
          id_instr_n = 8'h00;
          ex_valid_n = 1'b0;
          ex_instr_n = 8'h00;
          wb_valid_n = 1'b0;
          wb_instr_n = 8'h00;
          retire_n   = {CNT_W{1'b0}};
        end else begin
          state_n = state_r;
        end
      end
      S_RUN: begin
        wb_valid_n = ex_valid_r;
        wb_instr_n = ex_instr_r;
        if (id_valid_r && (id_instr_r[7:6] == OP_HALT)) begin
          // HALT retires from ID: nothing more is fetched and pc stays at HALT+1.
          id_valid_n = 1'b0;
          ex_valid_n = 1'b0;
          ex_instr_n = 8'h00;
          state_n    = S_DRAIN;
        end else if (stall_s) begin
          ex_valid_n = 1'b0;
          ex_instr_n = 8'h00;
        end else begin
          id_valid_n = 1'b1;
          id_instr_n = instr_in;
          pc_n       = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
          ex_valid_n = id_valid_r;
          ex_instr_n = id_instr_r;
        end
      end
      S_DRAIN: begin
        id_valid_n = 1'b0;
        ex_valid_n = 1'b0;
        ex_instr_n = 8'h00;
        wb_valid_n = ex_valid_r;
        wb_instr_n = ex_instr_r;
        if (!ex_valid_r && !wb_valid_r) begin
          state_n = S_HALTED;
        end else begin
          state_n = S_DRAIN;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      pc_r       <= {PC_W{1'b0}};
      id_valid_r <= 1'b0;
      id_instr_r <= 8'h00;
      ex_valid_r <= 1'b0;
      ex_instr_r <= 8'h00;
      wb_valid_r <= 1'b0;
      wb_instr_r <= 8'h00;
      retire_r   <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_n;
      pc_r       <= pc_n;
      id_valid_r <= id_valid_n;
      id_instr_r <= id_instr_n;
      ex_valid_r <= ex_valid_n;
      ex_instr_r <= ex_instr_n;
      wb_valid_r <= wb_valid_n;
      wb_instr_r <= wb_instr_n;
      retire_r   <= retire_n;
    end
  end

  assign pc         = pc_r;
  assign id_valid   = id_valid_r;
  assign id_instr   = id_instr_r;
  assign ex_valid   = ex_valid_r;
  assign ex_instr   = ex_instr_r;
  assign wb_valid   = wb_valid_r;
  assign wb_instr   = wb_instr_r;
  assign fwd_a      = fwd_a_s;
  assign fwd_b      = fwd_b_s;
  assign stall      = stall_s;
  assign busy       = (state_r == S_RUN) || (state_r == S_DRAIN);
  assign halted     = (state_r == S_HALTED);
  assign retire_cnt = retire_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Instruction memory is a 16-entry array read combinationally at pc.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] instr_in;
  logic [3:0] pc;
  logic       id_valid, ex_valid, wb_valid;
  logic [7:0] id_instr, ex_instr, wb_instr;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, busy, halted;
  logic [7:0] retire_cnt;

  logic [7:0] imem [0:15];
  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.PC_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .instr_in(instr_in), .pc(pc),
    .id_valid(id_valid), .id_instr(id_instr), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .wb_valid(wb_valid), .wb_instr(wb_instr), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .busy(busy), .halted(halted), .retire_cnt(retire_cnt)
  );

  assign instr_in = imem[pc];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 20 && !halted; i++) tick();
    chk("halt_reached", halted, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_valids"}, {id_valid, ex_valid, wb_valid}, 0);
    chk({tag, "_instrs"}, {id_instr, ex_instr, wb_instr}, 0);
    chk({tag, "_fwd_stall"}, {fwd_a, fwd_b, stall}, 0);
    chk({tag, "_busy_halted"}, {busy, halted}, 0);
    chk({tag, "_retire"}, retire_cnt, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = 8'hC0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_vals("rst");
    tick();
    tick();
    chk("idle_pc_hold", pc, 0);
    chk("idle_not_busy", busy, 0);

    // ADD R1,R2 then SUB R1,R3: EX forward on operand A only.
    imem[0] = 8'h0A;
    imem[1] = 8'h4B;
    imem[2] = 8'hC0;
    do_start();
    chk("a_busy", busy, 1);
    chk("a_pc0", pc, 0);
    tick();
    chk("a_id_add", {id_valid, id_instr}, {1'b1, 8'h0A});
    chk("a_pc1", pc, 1);
    tick();
    chk("a_id_sub", {id_valid, id_instr}, {1'b1, 8'h4B});
    chk("a_fwd_a", fwd_a, 2'b01);
    chk("a_fwd_b", fwd_b, 2'b00);
    chk("a_stall", stall, 0);
    tick();
    chk("a_wb_add", {wb_valid, wb_instr}, {1'b1, 8'h0A});
    tick();
    chk("a_wb_sub", {wb_valid, wb_instr}, {1'b1, 8'h4B});
    chk("a_retire1", retire_cnt, 1);
    wait_halt();
    chk("a_retire2", retire_cnt, 2);
    chk("a_pc_end", pc, 3);

    // LOAD R4,[R5] then ADD R6,R4: one stall, then WB forward on operand B.
    imem[0] = 8'hA5;
    imem[1] = 8'h34;
    imem[2] = 8'hC0;
    do_start();
    chk("b_restart_pc", pc, 0);
    chk("b_restart_retire", retire_cnt, 0);
    chk("b_restart_busy", {busy, halted}, 2'b10);
    tick();
    chk("b_no_stall_yet", stall, 0);
    tick();
    chk("b_stall", stall, 1);
    chk("b_pc2", pc, 2);
    tick();
    chk("b_stall_once", stall, 0);
    chk("b_ex_bubble", ex_valid, 0);
    chk("b_pc_held", pc, 2);
    chk("b_id_held", {id_valid, id_instr}, {1'b1, 8'h34});
    chk("b_fwd_b", fwd_b, 2'b10);
    chk("b_fwd_a", fwd_a, 2'b00);
    tick();
    chk("b_ex_add", {ex_valid, ex_instr}, {1'b1, 8'h34});
    chk("b_pc3", pc, 3);
    wait_halt();
    chk("b_retire", retire_cnt, 2);

    // ADD R1,R2 / SUB R3,R4 / LOAD R5,[R6] / HALT.
    imem[0] = 8'h0A;
    imem[1] = 8'h5C;
    imem[2] = 8'hAE;
    imem[3] = 8'hC0;
    do_start();
    for (int i = 0; i < 20 && !halted; i++) begin
      tick();
      chk("c_halt_not_in_ex", {1'b0, ex_valid && (ex_instr[7:6] == 2'b11)}, 0);
    end
    chk("c_halted", {busy, halted}, 2'b01);
    chk("c_retire", retire_cnt, 3);
    chk("c_pc", pc, 4);

    // 16 ADDs with rotating destinations: pc wrap, start ignored in RUN,
    // then reset mid-RUN.
    for (int i = 0; i < 16; i++) imem[i] = {2'b00, 3'((i % 3) + 1), 3'b000};
    do_start();
    for (int k = 1; k <= 15; k++) tick();
    chk("d_pc15", pc, 15);
    chk("d_stall_none", stall, 0);
    tick();
    chk("d_pc_wrap", pc, 0);
    chk("d_retire13", retire_cnt, 13);
    do_start();
    chk("d_start_ignored_pc", pc, 1);
    chk("d_start_ignored_cnt", retire_cnt, 14);
    chk("d_still_busy", busy, 1);
    for (int k = 0; k < 4; k++) tick();
    chk("d_pc5", pc, 5);
    chk("d_retire18", retire_cnt, 18);
    chk("d_all_valid", {id_valid, ex_valid, wb_valid}, 3'b111);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_retire", retire_cnt, 0);
    chk("post_rst_pc", pc, 0);
    chk("post_rst_idle", {busy, halted}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
